// File: rtl/zb_tx_pkg.sv
// zb_tx_pkg: shared types and constants for the nibble packer / serializer.
package zb_tx_pkg;
    typedef logic [3:0] nibble_t;
    typedef logic [7:0] byte_t;
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} ser_state_t;
    localparam int BITS_PER_BYTE = 8;
endpackage

// File: rtl/nibble_byte_fifo.sv
// nibble_byte_fifo: synchronous byte FIFO with registered occupancy count.
// A push while full is honoured only when a pop happens in the same cycle.
module nibble_byte_fifo
    import zb_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  byte_t                  wdata,
    output byte_t                  rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    byte_t         mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;
    assign rdata = mem_q[rptr_q];

    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end
endmodule

// File: rtl/nibble_pack_tx.sv
// nibble_pack_tx: packs nibble pairs (low first) into bytes, buffers them and shifts them
// out LSB-first on one pin. Define NIBBLE_PACK_PARITY_EN to append an even-parity bit per frame.
module nibble_pack_tx
    import zb_tx_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int CLK_DIV = 4
) (
    input  logic                   inClock,
    input  logic                   inReset,
    input  logic [3:0]             inNibble,
    input  logic                   inNibbleValid,
    output logic                   outNibbleReady,
    input  logic                   inFlush,
    output logic                   outSerData,
    output logic                   outSerFrame,
    output logic                   outBitStrobe,
    output logic [$clog2(DEPTH):0] outFifoCount,
    output logic                   outOverflow
);
    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [2:0]    BIT_LAST = 3'(BITS_PER_BYTE - 1);

    nibble_t       hold_q, hold_d;
    logic          hold_vld_q, hold_vld_d;
    logic          ovf_q, ovf_d;
    logic          rdy_en_q;
    ser_state_t    state_q, state_d;
    byte_t         shreg_q, shreg_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [DW-1:0] divcnt_q, divcnt_d;
    logic          frame_q, frame_d, data_q, data_d, strobe_q, strobe_d;
    logic          push, pop, full, empty, fin, accept, room;
    byte_t         wdata, rdata;
`ifdef NIBBLE_PACK_PARITY_EN
    logic          par_q, par_d;
`endif

    nibble_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (inClock),
        .rst_n (inReset),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .count (outFifoCount),
        .full  (full),
        .empty (empty)
    );

    // A byte may enter a full FIFO only when the serializer pops in the same cycle
    assign room           = !full || pop;
    assign outNibbleReady = rdy_en_q && room;
    assign accept         = inNibbleValid && outNibbleReady;
    assign outSerData     = data_q;
    assign outSerFrame    = frame_q;
    assign outBitStrobe   = strobe_q;
    assign outOverflow    = ovf_q;

    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        push       = 1'b0;
        wdata      = {inNibble, hold_q};
        if (accept) begin
            push       = hold_vld_q;
            hold_d     = hold_vld_q ? hold_q : inNibble;
            hold_vld_d = !hold_vld_q;
        end
        if (inFlush && hold_vld_d && room) begin
            push       = 1'b1;
            wdata      = {4'h0, hold_d};
            hold_vld_d = 1'b0;
        end
        ovf_d = ovf_q || (inNibbleValid && !outNibbleReady);
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        divcnt_d = (divcnt_q == DIV_LAST) ? '0 : divcnt_q + 1'b1;
        pop      = 1'b0;
        fin      = 1'b0;
`ifdef NIBBLE_PACK_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            SHIFT: begin
                if (divcnt_q == DIV_LAST) begin
                    shreg_d  = shreg_q >> 1;
                    bitcnt_d = bitcnt_q + 3'd1;
                end
`ifdef NIBBLE_PACK_PARITY_EN
                if (divcnt_q == DIV_LAST && bitcnt_q == BIT_LAST) state_d = PAR;
            end
            PAR: fin = divcnt_q == DIV_LAST;
`else
                fin = divcnt_q == DIV_LAST && bitcnt_q == BIT_LAST;
            end
`endif
            default: fin = 1'b1;
        endcase
        // End of frame (or idle): reload straight from the FIFO so frames run back to back
        if (fin) begin
            pop      = !empty;
            state_d  = empty ? IDLE : SHIFT;
            shreg_d  = rdata;
            bitcnt_d = '0;
            divcnt_d = '0;
`ifdef NIBBLE_PACK_PARITY_EN
            par_d    = ^rdata;
`endif
        end
        frame_d  = state_d != IDLE;
`ifdef NIBBLE_PACK_PARITY_EN
        data_d   = (state_d == SHIFT && shreg_d[0]) || (state_d == PAR && par_d);
`else
        data_d   = state_d == SHIFT && shreg_d[0];
`endif
        strobe_d = frame_d && divcnt_d == '0;
    end

    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
            rdy_en_q   <= 1'b0;
            state_q    <= IDLE;
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            divcnt_q   <= '0;
            frame_q    <= 1'b0;
            data_q     <= 1'b0;
            strobe_q   <= 1'b0;
`ifdef NIBBLE_PACK_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            ovf_q      <= ovf_d;
            rdy_en_q   <= 1'b1;
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            divcnt_q   <= divcnt_d;
            frame_q    <= frame_d;
            data_q     <= data_d;
            strobe_q   <= strobe_d;
`ifdef NIBBLE_PACK_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end
endmodule

// File: doc/nibble_pack_tx.md
Name: nibble_pack_tx

Overview:
- Output-side stage placed directly downstream of the core's 4-bit MUX outputs (out_MUX_outMUX9/10 class) and upstream of a single BU12SP output pad.
- Packs pairs of 4-bit symbols into bytes, low nibble first.
- Buffers the bytes in a small synchronous FIFO.
- Serializes each byte LSB-first onto one pin, with a frame strobe and a per-bit strobe. This cuts the number of output pads needed.

Parameters:
- DEPTH, 4: byte FIFO depth. Power of two, at least 2.
- CLK_DIV, 4: inClock cycles per serial bit. Minimum 1.

Ports:
- inClock  in  1  single system clock, rising edge.
- inReset  in  1  asynchronous active-low reset.
- inNibble  in  4  symbol from core.
- inNibbleValid  in  1  inNibble is valid this cycle.
- outNibbleReady  out  1  block can accept a nibble.
- inFlush  in  1  1-cycle pulse: emit a half-filled byte padded with zeros.
- outSerData  out  1  serial data to pad, LSB first.
- outSerFrame  out  1  high while a byte is being shifted.
- outBitStrobe  out  1  1-cycle pulse on the first cycle of each bit.
- outFifoCount  out  $clog2(DEPTH)+1  bytes currently buffered.
- outOverflow  out  1  sticky: a nibble was offered while ready was low.

Behaviour:
- Reset (inReset=0, asynchronous, one clock, active-low): all outputs go to 0 immediately. FIFO emptied, half-byte holder cleared, FSM forced to IDLE. A byte in flight is abandoned and never resent. outNibbleReady becomes 1 on the first clock after release.
- Accept: a nibble is taken when inNibbleValid && outNibbleReady.
  - If the holder is empty, the nibble is stored as the low nibble.
  - If the holder is occupied, {new, held} is pushed as one byte and the holder is cleared.
- outNibbleReady = (outFifoCount < DEPTH). A nibble that fills the holder is accepted even when the FIFO is full only if a pop happens in the same cycle. Otherwise ready is low.
- Overflow: inNibbleValid=1 while outNibbleReady=0 sets outOverflow. The nibble is dropped. Only reset clears outOverflow.
- Flush: handled after any accept in the same cycle.
  - If the holder is occupied after the accept, push {4'h0, held} and clear the holder.
  - If the holder is empty, no effect.
  - If a flush push would overflow the FIFO, the flush is ignored and the holder is kept.
- FIFO: simultaneous push and pop allowed at any count, including full with a pop and empty with a push. outFifoCount is registered.
- Serializer FSM states: IDLE, SHIFT (plus PAR with PARITY_EN).
  - IDLE: if the FIFO is not empty, pop into shreg and clear bitcnt and divcnt. Go to SHIFT next cycle.
  - SHIFT: outSerFrame=1 and outSerData=shreg[0]. divcnt counts 0..CLK_DIV-1; outBitStrobe=1 when divcnt==0. On divcnt==CLK_DIV-1, shift right and increment bitcnt.
  - After bit 7: if the FIFO is not empty, pop and reload in the same cycle. The next byte's bit 0 follows with no gap and outSerFrame stays high. Otherwise go to IDLE, and frame falls on the next cycle.
- Latency: with the FIFO empty and the FSM in IDLE, the second nibble is accepted at edge N. The byte is visible at N+1. outSerFrame rises and bit 0 appears at N+2.
- In IDLE, outSerData=0 and outBitStrobe=0.

Optional Feature:
- Macro NIBBLE_PACK_PARITY_EN.
- Defined: after bit 7 the FSM enters PAR. PAR drives even parity (XOR of the 8 data bits) for CLK_DIV cycles, with frame high and a strobe pulse. Back-to-back reload happens at the end of PAR.
- Undefined: the PAR state and its logic are absent; 8 bits per frame.

Decomposition:
- Package zb_tx_pkg:
  - nibble_t (4b) and byte_t (8b)
  - ser_state_t enum {IDLE, SHIFT, PAR}
  - constant BITS_PER_BYTE=8
- Sub-module nibble_byte_fifo: a parameterized synchronous byte FIFO with push, pop, count, full and empty, using the same clock and reset. The top level contains the packer, the flush logic and the serializer FSM.

Test Plan (defaults DEPTH=4, CLK_DIV=4):
- Basic pack: nibbles 0x5 then 0xA on consecutive cycles. Expect byte 0xA5. outSerData is 1,0,1,0,0,1,0,1, each held 4 cycles, with frame high for 32 cycles and 8 strobes.
- Flush: nibble 0x3 then inFlush. Expect byte 0x03 serialized. A second flush with the holder empty causes no activity.
- Full and overflow: 12 nibbles back-to-back.
  - First byte pops immediately and 4 bytes buffer, so outFifoCount=4.
  - outNibbleReady falls after nibble 10. Nibbles 11 and 12 set outOverflow=1.
  - Frame stays high for 5x32 cycles with no gaps.
- Reset mid-byte: assert inReset at bit 3 of 0xA5. All outputs are 0 in the same cycle and the count is 0. After release, new nibbles 0x1,0x2 give 0x21 only.
- Simultaneous flush and accept: holder contains 0x7, then 0xC with inFlush. Expect one byte 0xC7 and no extra zero byte. With the holder empty, 0x9 with inFlush gives byte 0x09.
- PARITY_EN build: bytes 0xA5 then 0x07. Expect parity bits 0 then 1 and frame high for 36 cycles per byte.
